// File: rtl/spi_master_arbiter_if.sv
// Request/response and SPI-master signal bundle for spi_master_arbiter.
// The arbiter uses the slave modport; clients and the SPI master use master.
interface spi_master_arbiter_if #(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int NUM_REQ           = 4
);
  localparam int DW = 2 ** SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG + 2;
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*CW-1:0] req_width;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [IW-1:0]         resp_id;
  logic [DW-1:0]         resp_data;
  logic                  resp_err;
  logic                  busy;
  logic                  spi_start;
  logic                  spi_finish;
  logic                  config_req;
  logic [CW-1:0]         config_data;
  logic [DW-1:0]         spi_din;
  logic [DW-1:0]         spi_dout;

  modport slave (
    input  req_valid, req_width, req_data, spi_finish, spi_dout,
    output req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
           spi_start, config_req, config_data, spi_din
  );

  modport master (
    output req_valid, req_width, req_data, spi_finish, spi_dout,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
           spi_start, config_req, config_data, spi_din
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master among NUM_REQ requesters, with
// width reprogramming only on change and a bounded wait for spi_finish.
module spi_master_arbiter #(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int NUM_REQ           = 4,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_master_arbiter_if.slave bus
);
  localparam int DW = 2 ** SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG + 2;
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CFG, GAP, START, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [IW-1:0] ptr, win, id_q;
  logic [IW:0]   idx;
  logic          found;
  logic [CW-1:0] win_w, width_q, cache_w;
  logic [DW-1:0] win_d, data_q, rdata_q;
  logic          win_bad, cache_vld, err_q, timeout_hit;
  logic [TW-1:0] cnt;

  // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign win_w       = bus.req_width[int'(win)*CW +: CW];
  assign win_d       = bus.req_data[int'(win)*DW +: DW];
  assign win_bad     = (win_w > CW'(DW - 1));
  // The counter lags the WAIT cycle count by one, hence the -2.
  assign timeout_hit = (cnt == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    unique case (state)
      IDLE: if (found) begin
        bus.req_ready[win] = 1'b1;
        if (win_bad)                           state_nx = RESP;
        else if (!cache_vld || cache_w != win_w) state_nx = CFG;
        else                                   state_nx = START;
      end
      CFG:   state_nx = GAP;
      GAP:   state_nx = START;
      START: state_nx = WAIT;
      WAIT:  if (bus.spi_finish || timeout_hit) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      id_q      <= '0;
      width_q   <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cache_w   <= '0;
      cache_vld <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          id_q    <= win;
          width_q <= win_w;
          data_q  <= win_d;
          rdata_q <= '0;
          err_q   <= win_bad;
          ptr     <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
        end
        CFG: begin
          cache_w   <= width_q;
          cache_vld <= 1'b1;
        end
        START: cnt <= '0;
        // A finish in the timeout cycle still counts as normal completion.
        WAIT: if (bus.spi_finish) begin
          rdata_q <= bus.spi_dout;
          err_q   <= 1'b0;
        end else if (timeout_hit) begin
          err_q     <= 1'b1;
          cache_vld <= 1'b0;
        end else begin
          cnt <= cnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = id_q;
  assign bus.resp_data   = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.spi_start   = (state == START);
  assign bus.config_req  = (state == CFG);
  assign bus.config_data = (state == CFG) ? width_q : cache_w;
  assign bus.spi_din     = bus.busy ? data_q : '0;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: table of single transfers plus
// round-robin and reset-during-WAIT sequences.
module tb_spi_master_arbiter;
  localparam int LOGW = 4;
  localparam int NR   = 4;
  localparam int TO   = 20;
  localparam int DW   = 16;
  localparam int CW   = 6;
  localparam int IW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.SPI_MAX_WIDTH_LOG(LOGW), .NUM_REQ(NR)) bus ();

  spi_master_arbiter #(
    .SPI_MAX_WIDTH_LOG(LOGW),
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          id;
    int          width;
    logic [15:0] data;
    logic [15:0] sw;       // word returned by the slave
    int          fd;       // finish delay after spi_start, 0 = never
    bit          exp_cfg;
    bit          exp_err;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt[8];
  int   rr_ord[5];

  int n_cmp = 0;
  int n_bad = 0;

  logic [NR-1:0] s_ready;
  logic          s_rv, s_err, s_busy, s_start, s_cfg;
  logic [IW-1:0] s_id;
  logic [DW-1:0] s_data, s_din;
  logic [CW-1:0] s_cfgd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Inputs are set before the call; outputs sampled 1ns later, then wait one cycle.
  task automatic tick();
    #1;
    s_ready = bus.req_ready;
    s_rv    = bus.resp_valid;
    s_id    = bus.resp_id;
    s_data  = bus.resp_data;
    s_err   = bus.resp_err;
    s_busy  = bus.busy;
    s_start = bus.spi_start;
    s_cfg   = bus.config_req;
    s_cfgd  = bus.config_data;
    s_din   = bus.spi_din;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_width  = '0;
    bus.req_data   = '0;
    bus.spi_finish = 1'b0;
    bus.spi_dout   = '0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, " ready"}, 32'(s_ready), 32'(0));
    chk({pfx, " ctl"}, 32'({s_rv, s_err, s_busy, s_start, s_cfg}), 32'(0));
    chk({pfx, " id"}, 32'(s_id), 32'(0));
    chk({pfx, " data"}, 32'(s_data), 32'(0));
    chk({pfx, " cfgd"}, 32'(s_cfgd), 32'(0));
    chk({pfx, " din"}, 32'(s_din), 32'(0));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic xfer(input int vi, input vec_t v);
    int   t_grant, t_cfg, t_start, fin_at, n_cfg, n_start, t_rv;
    logic [CW-1:0] cfgv;
    bit   granted, done, illegal;
    t_grant = -10; t_cfg = -1; t_start = -1; fin_at = -1; t_rv = -1;
    n_cfg = 0; n_start = 0; granted = 1'b0; done = 1'b0; cfgv = '0;
    illegal = (v.width > DW - 1);
    bus.req_width[v.id*CW +: CW] = CW'(v.width);
    bus.req_data[v.id*DW +: DW]  = v.data;
    for (int c = 0; c < 100 && !done; c++) begin
      bus.req_valid = granted ? '0 : (NR'(1) << v.id);
      // A stray finish right after the grant must be ignored.
      bus.spi_finish = (c == fin_at) || (c == t_grant + 1);
      bus.spi_dout   = (c == fin_at) ? v.sw : ((c == t_grant + 1) ? 16'hFFFF : 16'h0000);
      tick();
      if (s_ready != '0 && !granted) begin
        granted = 1'b1;
        t_grant = c;
        chk($sformatf("v%0d ready", vi), 32'(s_ready), 32'(NR'(1) << v.id));
      end
      if (s_cfg) begin
        n_cfg++;
        t_cfg = c;
        cfgv  = s_cfgd;
      end
      if (s_start) begin
        n_start++;
        t_start = c;
        chk($sformatf("v%0d din", vi), 32'(s_din), 32'(v.data));
        if (v.fd > 0) fin_at = c + v.fd;
      end
      if (s_rv) begin
        done = 1'b1;
        t_rv = c;
        chk($sformatf("v%0d resp_id", vi), 32'(s_id), 32'(v.id));
        chk($sformatf("v%0d resp_err", vi), 32'(s_err), 32'(v.exp_err));
        chk($sformatf("v%0d resp_data", vi), 32'(s_data), 32'(v.exp_data));
        chk($sformatf("v%0d busy", vi), 32'(s_busy), 32'(1));
      end
    end
    bus.req_valid  = '0;
    bus.spi_finish = 1'b0;
    bus.spi_dout   = '0;
    chk($sformatf("v%0d completed", vi), 32'(done), 32'(1));
    chk($sformatf("v%0d cfg_count", vi), 32'(n_cfg), 32'(v.exp_cfg ? 1 : 0));
    if (v.exp_cfg) begin
      chk($sformatf("v%0d cfg_time", vi), 32'(t_cfg), 32'(t_grant + 1));
      chk($sformatf("v%0d cfg_data", vi), 32'(cfgv), 32'(v.width));
    end
    if (illegal) begin
      chk($sformatf("v%0d start_count", vi), 32'(n_start), 32'(0));
      chk($sformatf("v%0d resp_time", vi), 32'(t_rv), 32'(t_grant + 1));
    end else begin
      chk($sformatf("v%0d start_count", vi), 32'(n_start), 32'(1));
      chk($sformatf("v%0d start_time", vi), 32'(t_start), 32'(t_grant + (v.exp_cfg ? 3 : 1)));
      chk($sformatf("v%0d resp_time", vi), 32'(t_rv), 32'(t_start + ((v.fd > 0) ? v.fd + 1 : TO)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nrsp, fin_at, gid, nrv;
    //        id wid data      slave     fd cfg err exp_data
    vt[0] = '{0, 15, 16'hA5C3, 16'h3C5A, 3,  1, 0, 16'h3C5A};
    vt[1] = '{0, 15, 16'h1234, 16'hBEEF, 3,  0, 0, 16'hBEEF};
    vt[2] = '{1, 7,  16'h0055, 16'h00AA, 2,  1, 0, 16'h00AA};
    vt[3] = '{1, 15, 16'hFFFF, 16'h0001, 5,  1, 0, 16'h0001};
    vt[4] = '{2, 16, 16'h1111, 16'h9999, 3,  0, 1, 16'h0000};
    vt[5] = '{3, 15, 16'h2222, 16'h7777, 19, 0, 0, 16'h7777};
    vt[6] = '{3, 15, 16'h3333, 16'h6666, 0,  0, 1, 16'h0000};
    vt[7] = '{0, 15, 16'h4444, 16'h5555, 1,  1, 0, 16'h5555};
    rr_ord = '{0, 1, 2, 3, 0};

    clear_inputs();
    rst_n = 1'b0;
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) xfer(i, vt[i]);

    // All requesters held high: grants rotate 0,1,2,3,0.
    reset_dut();
    bus.req_width = {4{6'd15}};
    bus.req_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    ngr = 0; nrsp = 0; fin_at = -1; gid = 0;
    for (int c = 0; c < 300 && nrsp < 5; c++) begin
      bus.req_valid  = '1;
      bus.spi_finish = (c == fin_at);
      bus.spi_dout   = (c == fin_at) ? (16'hC000 | 16'(gid)) : 16'h0000;
      tick();
      if (s_ready != '0) begin
        if (ngr < 5) begin
          chk($sformatf("rr grant%0d", ngr), 32'(s_ready), 32'(NR'(1) << rr_ord[ngr]));
          gid = rr_ord[ngr];
        end
        ngr++;
      end
      if (s_start) fin_at = c + 2;
      if (s_rv) begin
        chk($sformatf("rr resp_id%0d", nrsp), 32'(s_id), 32'(rr_ord[nrsp]));
        chk($sformatf("rr resp_data%0d", nrsp), 32'(s_data), 32'(16'hC000 | 16'(rr_ord[nrsp])));
        nrsp++;
      end
    end
    chk("rr responses", 32'(nrsp), 32'(5));
    clear_inputs();
    tick();
    tick();

    // Reset asserted while waiting for spi_finish.
    reset_dut();
    bus.req_width[0 +: CW] = 6'd15;
    bus.req_data[0 +: DW]  = 16'hABCD;
    ngr = 0;
    for (int c = 0; c < 20 && ngr == 0; c++) begin
      bus.req_valid = 4'b0001;
      tick();
      if (s_ready != '0) bus.req_valid = '0;
      if (s_start) ngr = 1;
    end
    bus.req_valid = '0;
    chk("rst_mid start_seen", 32'(ngr), 32'(1));
    tick();
    chk("rst_mid in_wait busy", 32'(s_busy), 32'(1));
    rst_n = 1'b0;
    tick();
    check_zero("rst_mid");
    rst_n = 1'b1;
    nrv = 0;
    for (int c = 0; c < 30; c++) begin
      bus.spi_finish = (c == 2);
      bus.spi_dout   = 16'h1357;
      tick();
      if (s_rv) nrv++;
    end
    chk("rst_mid no_resp", 32'(nrv), 32'(0));
    chk("rst_mid idle", 32'(s_busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_interface_master among NUM_REQ independent requesters using round-robin arbitration.
- For each granted request it reprograms the transfer width only if the width changed, pulses spi_start, waits for spi_finish, and returns the received word tagged with the requester ID.
- Sits between client logic and spi_interface_master, and owns the master's config_req, config_data, spi_start and din inputs.

Parameters:
- SPI_MAX_WIDTH_LOG, 4, log2 of the maximum word width. DW = 2**SPI_MAX_WIDTH_LOG. CW = SPI_MAX_WIDTH_LOG+2.
- NUM_REQ, 4, number of requesters (2..8). IW = $clog2(NUM_REQ).
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for spi_finish after spi_start before aborting.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until the matching req_ready
- req_width  in  NUM_REQ*CW  per-requester width code (bits minus 1; 15 means 16 bits); slice i = [i*CW +: CW]
- req_data  in  NUM_REQ*DW  per-requester MOSI word; slice i = [i*DW +: DW]
- req_ready  out  NUM_REQ  one-hot accept pulse
- resp_valid  out  1  one-cycle response strobe
- resp_id  out  IW  index of the requester being answered
- resp_data  out  DW  MISO word captured from the master
- resp_err  out  1  qualifies resp_valid: illegal width or timeout
- busy  out  1  high in every state except IDLE
- spi_start  out  1  to master spi_start
- spi_finish  in  1  from master spi_finish
- config_req  out  1  to master config_req
- config_data  out  CW  to master config_data
- spi_din  out  DW  to master din
- spi_dout  in  DW  from master dout

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0; state IDLE; round-robin pointer 0; cached width marked invalid; timeout counter 0.
- States: IDLE, CFG, GAP, START, WAIT, RESP.
- IDLE:
  - With any req_valid set, pick the first set bit searching from ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle (combinational from req_valid and state; the handshake completes in that cycle).
  - Latch id, width and data; set ptr = winner+1 modulo NUM_REQ.
  - If width > DW-1, go to RESP with resp_err=1 and no SPI activity.
  - Else if the cached width is invalid or differs from the latched width, go to CFG.
  - Otherwise go to START.
- CFG: config_req=1 and config_data=width for exactly one cycle; update the cached width; go to GAP.
- GAP: one idle cycle so the master settles; go to START.
- START: spi_start=1 for one cycle; clear the timeout counter; go to WAIT.
- spi_din carries the latched data from the CFG/START entry until RESP exits. config_data holds its last value outside CFG.
- WAIT:
  - On spi_finish=1, capture spi_dout into resp_data and go to RESP with resp_err=0.
  - Else increment the counter; when it reaches TIMEOUT_CYCLES-1, go to RESP with resp_err=1, resp_data=0, and invalidate the cached width.
- RESP: resp_valid=1 for one cycle with resp_id, resp_data and resp_err; return to IDLE. New requests are not granted in RESP.
- Latency, width unchanged: accept at T, spi_start at T+1, resp_valid one cycle after the spi_finish cycle.
- Latency, width changed: config_req at T+1, spi_start at T+3.
- spi_finish outside WAIT is ignored. A spi_finish arriving in the timeout cycle wins (normal completion).
- req_valid deasserted before the grant is not an error; that requester is simply skipped.
- Requests arriving while busy wait. Each requester has at most one outstanding request.
- Reset mid-transfer: abort immediately; no response is issued.

Test Plan:
- Single request: req 0, width 15, data 16'hA5C3; slave returns 16'h3C5A. Expect config_req once with config_data=15, then spi_start, then resp_valid with id 0, data 16'h3C5A, err 0.
- Same width back-to-back: two req 0 transfers at width 15. The second issues no config_req; spi_start comes one cycle after the req_ready pulse.
- Width change: req 1 at width 7, then req 1 at width 15. config_req fires before each transfer with values 7 and 15.
- Round robin: all four req_valid held high. Grant order 0,1,2,3,0; each resp_id matches its grant.
- Illegal width: req 2 with width 16 (CW=6). Expect req_ready[2], then resp_valid with err 1, with no spi_start and no config_req.
- Timeout and reset: set TIMEOUT_CYCLES=20 and never return spi_finish. Expect resp_err=1 at spi_start+20; the next request re-issues config_req. Then assert rst_n low during WAIT: all outputs go to 0 and no resp_valid follows.
